// File: rtl/urv_irq_ctrl.sv
// urv_irq_ctrl: fixed-priority interrupt controller with a request/claim/complete FSM.
// Define URV_IRQ_EDGE_EN to get per-channel edge mode (writable MODE); otherwise every channel is level.
module urv_irq_ctrl #(
    parameter int unsigned N_IRQ      = 8,
    parameter logic [31:0] RESET_MODE = 32'h0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             csr_we_i,
    input  logic [1:0]       csr_sel_i,
    input  logic [31:0]      csr_wdata_i,
    output logic [31:0]      csr_rdata_o,
    output logic             irq_o,
    output logic [4:0]       irq_id_o,
    input  logic             ack_i,
    input  logic             eret_i,
    output logic [N_IRQ-1:0] pending_o
);

    localparam logic [1:0] SEL_ENABLE  = 2'd0;
    localparam logic [1:0] SEL_MODE    = 2'd1;
    localparam logic [1:0] SEL_PENDING = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_irq;
    logic [4:0]       r_claim_id;
    logic [N_IRQ-1:0] r_enable;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] w_pending_next;
    logic [N_IRQ-1:0] w_mode;
    logic [N_IRQ-1:0] w_cand;
    logic [N_IRQ-1:0] w_wdata_n;
    logic [4:0]       w_winner;
    logic             r_gie;
    logic             r_pgie;
    logic             w_take;
    logic             w_done;
    logic             w_unused;

    assign w_wdata_n = csr_wdata_i[N_IRQ-1:0];
    assign w_cand    = r_pending & r_enable;
    assign w_take    = (r_state == REQ) && ack_i;
    assign w_done    = (r_state == SERVICE) && eret_i;
    // High write-data bits and, in level-only builds, RESET_MODE have no effect.
    assign w_unused  = ^{csr_wdata_i, RESET_MODE};

    always_comb begin
        w_winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) w_winner = 5'(i);
        end
    end

`ifdef URV_IRQ_EDGE_EN
    logic [N_IRQ-1:0] r_mode;
    logic [N_IRQ-1:0] r_irq_q;
    logic             r_armed;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_claim_mask;
    logic [N_IRQ-1:0] w_w1c_mask;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mode  <= RESET_MODE[N_IRQ-1:0];
            r_irq_q <= '0;
            r_armed <= 1'b0;
        end else begin
            r_irq_q <= irq_i;
            r_armed <= 1'b1;
            if (csr_we_i && csr_sel_i == SEL_MODE) r_mode <= w_wdata_n;
        end
    end

    // r_armed masks the first sample after reset so a line held high through reset is not an edge.
    assign w_rise       = irq_i & ~r_irq_q & {N_IRQ{r_armed}};
    assign w_claim_mask = w_take ? (w_cand & (-w_cand)) : '0;
    assign w_w1c_mask   = (csr_we_i && csr_sel_i == SEL_PENDING) ? w_wdata_n : '0;
    assign w_clr        = w_claim_mask | w_w1c_mask;
    assign w_mode       = r_mode;

    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
        assign w_pending_next[gi] = r_mode[gi] ? ((r_pending[gi] & ~w_clr[gi]) | w_rise[gi])
                                               : irq_i[gi];
    end
`else
    assign w_mode         = '0;
    assign w_pending_next = irq_i;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|w_cand && r_gie) w_state_next = REQ;
            REQ:     if (ack_i) w_state_next = SERVICE;
                     else if (!(|w_cand) || !r_gie) w_state_next = IDLE;
            SERVICE: if (eret_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_irq      <= 1'b0;
            r_claim_id <= '0;
            r_enable   <= '0;
            r_pending  <= '0;
            r_gie      <= 1'b0;
            r_pgie     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_irq     <= (w_state_next == REQ);
            r_pending <= w_pending_next;
            if (w_take)      r_claim_id <= w_winner;
            else if (w_done) r_claim_id <= '0;
            if (csr_we_i && csr_sel_i == SEL_ENABLE) r_enable <= w_wdata_n;
            // Claim/complete override a same-cycle software write of GIE.
            if (w_take) begin
                r_pgie <= r_gie;
                r_gie  <= 1'b0;
            end else if (w_done) begin
                r_gie  <= r_pgie;
            end else if (csr_we_i && csr_sel_i == 2'd3) begin
                r_gie  <= csr_wdata_i[0];
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_sel_i)
            SEL_ENABLE:  csr_rdata_o[N_IRQ-1:0] = r_enable;
            SEL_MODE:    csr_rdata_o[N_IRQ-1:0] = w_mode;
            SEL_PENDING: csr_rdata_o[N_IRQ-1:0] = r_pending;
            default:     csr_rdata_o[0]         = r_gie;
        endcase
    end

    assign irq_o     = r_irq;
    assign irq_id_o  = (r_state == REQ) ? w_winner : r_claim_id;
    assign pending_o = r_pending;

endmodule

// File: tb/tb_urv_irq_ctrl.sv
// Bench for urv_irq_ctrl: directed literal scenarios plus randomized traffic against a behavioural model.
module tb_urv_irq_ctrl;

    localparam int N = 8;
`ifdef URV_IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_i = 1'b0;
    logic [N-1:0]  irq   = '0;
    logic          we    = 1'b0;
    logic [1:0]    sel   = 2'd0;
    logic [31:0]   wdata = '0;
    logic          ack   = 1'b0;
    logic          eret  = 1'b0;
    logic [31:0]   rdata;
    logic          irq_o;
    logic [4:0]    id;
    logic [N-1:0]  pend;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    urv_irq_ctrl #(.N_IRQ(N), .RESET_MODE(32'h0)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .irq_i       (irq),
        .csr_we_i    (we),
        .csr_sel_i   (sel),
        .csr_wdata_i (wdata),
        .csr_rdata_o (rdata),
        .irq_o       (irq_o),
        .irq_id_o    (id),
        .ack_i       (ack),
        .eret_i      (eret),
        .pending_o   (pend)
    );

    // Behavioural model: phase 0 = nothing requested, 1 = requesting, 2 = handler running.
    logic [N-1:0] m_pend  = '0;
    logic [N-1:0] m_en    = '0;
    logic [N-1:0] m_mode  = '0;
    logic [N-1:0] m_prev  = '0;
    logic         m_armed = 1'b0;
    logic         m_gie   = 1'b0;
    logic         m_pgie  = 1'b0;
    int           m_phase = 0;
    int           m_claim = 0;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [N-1:0] clear_mask(input logic [N-1:0] cand, input int phase,
                                                 input logic a, input logic w,
                                                 input logic [1:0] s, input logic [31:0] d);
        logic [N-1:0] c;
        c = (w && s == 2'd2) ? d[N-1:0] : '0;
        if (phase == 1 && a && cand != '0) c[lowest(cand)] = 1'b1;
        return c;
    endfunction

    function automatic logic [N-1:0] next_pending(input logic [N-1:0] p, input logic [N-1:0] mode,
                                                   input logic [N-1:0] line, input logic [N-1:0] prev,
                                                   input logic armed, input logic [N-1:0] clr);
        logic [N-1:0] n;
        for (int i = 0; i < N; i++) begin
            if (mode[i]) n[i] = (p[i] && !clr[i]) || (armed && line[i] && !prev[i]);
            else         n[i] = line[i];
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_pend <= '0; m_en <= '0; m_mode <= '0; m_prev <= '0; m_armed <= 1'b0;
            m_gie <= 1'b0; m_pgie <= 1'b0; m_phase <= 0; m_claim <= 0;
        end else begin
            m_pend  <= next_pending(m_pend, m_mode, irq, m_prev, m_armed,
                                    clear_mask(m_pend & m_en, m_phase, ack, we, sel, wdata));
            m_prev  <= irq;
            m_armed <= 1'b1;
            if (we && sel == 2'd0) m_en <= wdata[N-1:0];
            if (EDGE && we && sel == 2'd1) m_mode <= wdata[N-1:0];
            if (m_phase == 1 && ack) begin
                m_pgie <= m_gie;
                m_gie  <= 1'b0;
            end else if (m_phase == 2 && eret) begin
                m_gie  <= m_pgie;
            end else if (we && sel == 2'd3) begin
                m_gie  <= wdata[0];
            end
            case (m_phase)
                0: if ((m_pend & m_en) != '0 && m_gie) m_phase <= 1;
                1: if (ack) begin
                       m_phase <= 2;
                       m_claim <= lowest(m_pend & m_en);
                   end else if ((m_pend & m_en) == '0 || !m_gie) begin
                       m_phase <= 0;
                   end
                default: if (eret) begin
                       m_phase <= 0;
                       m_claim <= 0;
                   end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic [1:0] s);
        case (s)
            2'd0:    return 32'(m_en);
            2'd1:    return 32'(m_mode);
            2'd2:    return 32'(m_pend);
            default: return 32'(m_gie);
        endcase
    endfunction

    always @(negedge clk) begin
        check("m_irq_o", 32'(irq_o), 32'(m_phase == 1));
        check("m_pending", 32'(pend), 32'(m_pend));
        check("m_rdata", rdata, model_rdata(sel));
        if (m_phase == 1 && (m_pend & m_en) != '0)
            check("m_id_req", 32'(id), 32'(lowest(m_pend & m_en)));
        if (m_phase == 2)
            check("m_id_svc", 32'(id), 32'(m_claim));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] s, input logic [31:0] d);
        we = 1'b1; sel = s; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        logic [N-1:0] flip;
        repeat (3) tick();
        #1;
        check("rst_irq_o", 32'(irq_o), 32'd0);
        check("rst_id", 32'(id), 32'd0);
        check("rst_pending", 32'(pend), 32'd0);
        sel = 2'd0; #1 check("rst_enable", rdata, 32'd0);
        sel = 2'd3; #1 check("rst_gie", rdata, 32'd0);
        sel = 2'd1; #1 check("rst_mode", rdata, 32'd0);
        rst_i = 1'b1;
        tick();
        wr(2'd0, 32'hFF);
        wr(2'd3, 32'h1);

        // Level channel 1: request, claim, complete while high, then drop in REQ.
        irq[1] = 1'b1;
        tick(); #1;
        check("lvl_pend", 32'(pend), 32'h02);
        check("lvl_irq_early", 32'(irq_o), 32'd0);
        tick(); #1;
        check("lvl_irq", 32'(irq_o), 32'd1);
        check("lvl_id", 32'(id), 32'd1);
        ack = 1'b1; sel = 2'd3;
        tick(); ack = 1'b0; #1;
        check("svc_irq", 32'(irq_o), 32'd0);
        check("svc_gie", rdata, 32'd0);
        check("svc_id", 32'(id), 32'd1);
        eret = 1'b1;
        tick(); eret = 1'b0; #1;
        check("eret_gie", rdata, 32'd1);
        tick(); #1;
        check("reassert_irq", 32'(irq_o), 32'd1);
        irq[1] = 1'b0;
        tick(); #1;
        check("drop_pend", 32'(pend), 32'h00);
        check("drop_irq_hold", 32'(irq_o), 32'd1);
        tick(); #1;
        check("drop_irq", 32'(irq_o), 32'd0);

        wr(2'd1, 32'hFF); #1;
        check("mode_read", rdata, EDGE ? 32'hFF : 32'h0);
`ifndef URV_IRQ_EDGE_EN
        irq[4] = 1'b1;
        tick(); #1 check("mirror_1", 32'(pend), 32'h10);
        tick(); #1 check("mirror_2", 32'(pend), 32'h10);
        irq[4] = 1'b0;
        tick(); #1 check("mirror_off", 32'(pend), 32'h00);
`endif
        repeat (3) tick();

        // Reset while a claim is in service.
        irq[1] = 1'b1;
        repeat (2) tick();
        ack = 1'b1;
        tick(); ack = 1'b0;
        rst_i = 1'b0; sel = 2'd0;
        #1;
        check("rst_svc_irq", 32'(irq_o), 32'd0);
        check("rst_svc_id", 32'(id), 32'd0);
        check("rst_svc_pend", 32'(pend), 32'd0);
        check("rst_svc_en", rdata, 32'd0);
        tick();
        rst_i = 1'b1; irq = '0;
        repeat (2) tick();

`ifdef URV_IRQ_EDGE_EN
        wr(2'd0, 32'hFF);
        wr(2'd3, 32'h1);
        wr(2'd1, 32'hFF);
        irq[3] = 1'b1;
        tick(); irq[3] = 1'b0; #1;
        check("edge3_pend", 32'(pend), 32'h08);
        tick(); #1;
        check("edge3_irq", 32'(irq_o), 32'd1);
        check("edge3_id", 32'(id), 32'd3);
        ack = 1'b1; tick(); ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        tick(); #1;
        check("edge3_clean", 32'(pend), 32'h00);
        irq = 8'h24;
        tick(); irq = '0;
        tick(); #1;
        check("pair_id", 32'(id), 32'd2);
        ack = 1'b1; tick(); ack = 1'b0; #1;
        check("pair_pend", 32'(pend), 32'h20);
        check("pair_svc_irq", 32'(irq_o), 32'd0);
        eret = 1'b1; tick(); eret = 1'b0;
        tick(); #1;
        check("pair_irq5", 32'(irq_o), 32'd1);
        check("pair_id5", 32'(id), 32'd5);
        ack = 1'b1; tick(); ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        irq[2] = 1'b1;
        tick(); irq[2] = 1'b0;
        tick();
        irq[2] = 1'b1; we = 1'b1; sel = 2'd2; wdata = 32'h04;
        tick(); we = 1'b0; irq[2] = 1'b0; #1;
        check("set_wins", 32'(pend), 32'h04);
        wr(2'd2, 32'h04);
        repeat (2) tick();
`endif

        // Randomized traffic, checked every cycle by the model compare process.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_i = ($urandom_range(0, 499) != 0);
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
            irq   = irq ^ flip;
            we    = ($urandom_range(0, 3) == 0);
            sel   = 2'($urandom_range(0, 3));
            wdata = $urandom;
            if (sel == 2'd3) wdata[0] = ($urandom_range(0, 3) != 0);
            ack   = !ack && ($urandom_range(0, 3) == 0);
            eret  = !eret && ($urandom_range(0, 5) == 0);
        end
        tick();
        we = 1'b0; ack = 1'b0; eret = 1'b0; rst_i = 1'b1;
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/urv_irq_ctrl.md
URV_IRQ_CTRL -- requirements
Module: urv_irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 8, number of interrupt channels, legal range 1..32.
REQ-002 Parameter RESET_MODE, default 0, reset value of the mode register (bit=1 edge, bit=0 level).
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 irq_i  input  N_IRQ  interrupt lines, already synchronous to clk_i.
REQ-006 csr_we_i  input  1  register write strobe, one write per cycle.
REQ-007 csr_sel_i  input  2  register select: 0 ENABLE, 1 MODE, 2 PENDING (write-1-to-clear), 3 GIE (bit 0).
REQ-008 csr_wdata_i  input  32  write data; bits at or above N_IRQ ignored.
REQ-009 csr_rdata_o  output  32  combinational read of the selected register, zero-extended.
REQ-010 irq_o  output  1  registered interrupt request to the core.
REQ-011 irq_id_o  output  5  channel number being requested or in service.
REQ-012 ack_i  input  1  core accepts the request (claim), single-cycle pulse.
REQ-013 eret_i  input  1  core finished the handler (complete), single-cycle pulse.
REQ-014 pending_o  output  N_IRQ  current pending register.

Function
REQ-015 Edge channel: pending bit SHALL set in the cycle after irq_i rises (0 in cycle t-1, 1 in cycle t); the bit holds until cleared.
REQ-016 Level channel: pending bit SHALL equal irq_i registered one cycle; PENDING writes have no effect on it.
REQ-017 Simultaneous edge set and write-1-to-clear of the same bit: set SHALL win.
REQ-018 Candidate vector = pending & ENABLE; winner = lowest-indexed set bit (fixed priority).
REQ-019 FSM states IDLE, REQ, SERVICE; irq_o SHALL be 1 only in REQ.
REQ-020 IDLE -> REQ when candidate vector non-zero and GIE=1; irq_id_o tracks the winner while in REQ.
REQ-021 REQ -> IDLE when the candidate vector becomes zero or GIE is cleared, without ack_i.
REQ-022 REQ with ack_i=1 -> SERVICE; the claimed id latches; GIE is saved into a prior-GIE bit and cleared; an edge-mode claimed pending bit clears in the same edge.
REQ-023 In SERVICE irq_id_o SHALL hold the claimed id; new pendings accumulate but raise no request.
REQ-024 SERVICE with eret_i=1 -> IDLE; GIE is restored from the prior-GIE bit.
REQ-025 ack_i outside REQ and eret_i outside SERVICE SHALL be ignored.
REQ-026 A GIE write in the same cycle as ack_i or eret_i: the FSM update SHALL win.
REQ-027 Latency: irq_i edge at cycle t with enable and GIE set -> irq_o=1 at cycle t+2.
REQ-028 ENABLE and MODE writes take effect on the next cycle; a channel switched from level to edge keeps its current pending value.

Reset
REQ-029 On rst_i low, asynchronously: FSM=IDLE, irq_o=0, irq_id_o=0, pending=0, ENABLE=0, GIE=0, prior-GIE=0, MODE=RESET_MODE, registered irq_i copy=0.
REQ-030 Reset in REQ or SERVICE SHALL abandon the claim; no eret_i is required afterwards.
REQ-031 After deassertion the block SHALL behave as freshly reset; a line held high through reset does not count as an edge.

Configuration
REQ-032 Macro URV_IRQ_EDGE_EN: when defined, MODE is writable and edge detection exists as specified.
REQ-033 Without URV_IRQ_EDGE_EN: all channels are level, MODE reads 0, MODE writes are ignored, RESET_MODE is ignored, and there is no edge register.

Verification
REQ-034 N_IRQ=8, ENABLE=0xFF, GIE=1, MODE=0xFF, pulse irq_i[3] at t -> pending_o=0x08 at t+1, irq_o=1 and irq_id_o=3 at t+2.
REQ-035 irq_i[5] and irq_i[2] rise in the same cycle -> irq_id_o=2; ack_i -> SERVICE, pending_o=0x20, irq_o=0; eret_i -> irq_o=1 with id 5 two cycles later.
REQ-036 Level ch 1 held high, claimed then eret_i while still high -> irq_o re-asserts; deassert irq_i[1] in REQ -> FSM back to IDLE, irq_o=0.
REQ-037 Edge pending 0x04 with PENDING write 0x04 in the same cycle as a new rising edge on ch 2 -> pending_o stays 0x04.
REQ-038 GIE=1, ack_i pulse -> csr_rdata_o (sel 3)=0 in SERVICE; eret_i -> reads 1.
REQ-039 rst_i low in SERVICE -> all outputs 0 immediately; build without URV_IRQ_EDGE_EN, write MODE=0xFF -> read 0, a pulsed line mirrors into pending only for its duration.
